// File: rtl/reg_wb_ctrl.sv
// Register-file writeback arbiter: pipeline port A has strict priority over a
// queued long-latency port B, with WAW kill of stale queued writes and hazard query.
module reg_wb_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic [4:0]  wreg,
    output logic [31:0] wdata,
    output logic        regWrite,
    input  logic [4:0]  rreg_a,
    input  logic [4:0]  rreg_b,
    output logic        pend_a,
    output logic        pend_b,
    output logic [3:0]  fifo_count
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    logic [4:0]       reg_q  [DEPTH];
    logic [4:0]       reg_d  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [3:0]       count_q, count_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [31:0]      wdata_q, wdata_d;

    logic a_req;
    logic push;
    logic pop;
    logic hit_a;
    logic hit_b;

    assign b_ready = !rst && (count_q < DEPTH_C);
    assign a_req   = a_valid && (a_reg != '0);
    assign push    = b_valid && b_ready && (b_reg != '0);
    assign pop     = !a_req && (count_q != '0);

    always_comb begin
        reg_d      = reg_q;
        data_d     = data_q;
        live_d     = live_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;

        if (a_req) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (reg_q[PW'(i)] == a_reg) begin
                    live_d[PW'(i)] = 1'b0;
                end
            end
            regwrite_d = 1'b1;
            wreg_d     = a_reg;
            wdata_d    = a_data;
        end else if (pop) begin
            // A killed head still frees its slot but leaves the write port idle.
            regwrite_d = live_q[head_q];
            if (live_q[head_q]) begin
                wreg_d  = reg_q[head_q];
                wdata_d = data_q[head_q];
            end
            live_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end

        if (push) begin
            reg_d[tail_q]  = b_reg;
            data_d[tail_q] = b_data;
            live_d[tail_q] = !(a_req && (a_reg == b_reg));
            tail_d         = tail_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            live_q     <= live_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Payload needs no reset: a slot is only ever read while its live bit is set.
    always_ff @(posedge clk) begin
        reg_q  <= reg_d;
        data_q <= data_d;
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[PW'(i)] && (reg_q[PW'(i)] == rreg_a)) hit_a = 1'b1;
            if (live_q[PW'(i)] && (reg_q[PW'(i)] == rreg_b)) hit_b = 1'b1;
        end
    end

    assign pend_a = (rreg_a != '0) && ((regwrite_q && (wreg_q == rreg_a)) || hit_a);
    assign pend_b = (rreg_b != '0) && ((regwrite_q && (wreg_q == rreg_b)) || hit_b);

    assign regWrite   = regwrite_q;
    assign wreg       = wreg_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback rules.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        regWrite;
    logic [4:0]  rreg_a;
    logic [4:0]  rreg_b;
    logic        pend_a;
    logic        pend_b;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    reg_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .wreg(wreg), .wdata(wdata), .regWrite(regWrite),
        .rreg_a(rreg_a), .rreg_b(rreg_b), .pend_a(pend_a), .pend_b(pend_b),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } entry_t;

    entry_t      mq[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    task automatic model_update();
        bit     a_req;
        bit     accept;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
            return;
        end
        a_req  = a_valid && (a_reg != 5'd0);
        accept = b_valid && (mq.size() < DEPTH);
        if (a_req) begin
            foreach (mq[i]) if (mq[i].r == a_reg) mq[i].live = 1'b0;
            m_rw = 1'b1; m_wreg = a_reg; m_wdata = a_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = e.live;
            if (e.live) begin
                m_wreg = e.r; m_wdata = e.d;
            end
        end else begin
            m_rw = 1'b0;
        end
        if (accept && b_reg != 5'd0) begin
            e.r = b_reg; e.d = b_data; e.live = !(a_req && a_reg == b_reg);
            mq.push_back(e);
        end
    endtask

    function automatic bit m_pend(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_rw && m_wreg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [44:0] exp_vec();
        return {m_rw, m_wreg, m_wdata, 4'(mq.size()),
                (!rst && mq.size() < DEPTH), m_pend(rreg_a), m_pend(rreg_b)};
    endfunction

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rreg_a = 5'd5; rreg_b = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(); tick();
        checks++;
        if ({regWrite, wreg, wdata, fifo_count} !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got rw=%b wreg=%0d wdata=%h cnt=%0d want all 0",
                     regWrite, wreg, wdata, fifo_count);
        end
        checks++;
        if (b_ready !== 1'b0) begin
            errors++; $display("FAIL reset_b_ready got %b want 0", b_ready);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({pend_a, pend_b, b_ready} !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_pend got pa=%b pb=%b rdy=%b want 0 0 1", pend_a, pend_b, b_ready);
        end
    endtask

    task automatic test_a_only();
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata} !== {1'b1, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL a_write got rw=%b wreg=%0d wdata=%h want 1 5 1234", regWrite, wreg, wdata);
        end
        drive(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata} !== {1'b0, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL a_reg0_idle got rw=%b wreg=%0d wdata=%h want 0 5 1234", regWrite, wreg, wdata);
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd3, 32'hBB, 1'b1, 5'd7, 32'hAA);
        tick();
        drive(1'b1, 5'd3, 32'hBB, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata, fifo_count} !== {1'b1, 5'd3, 32'hBB, 4'd1}) begin
            errors++;
            $display("FAIL prio_a_wins got rw=%b wreg=%0d wdata=%h cnt=%0d want 1 3 bb 1",
                     regWrite, wreg, wdata, fifo_count);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata, fifo_count} !== {1'b1, 5'd7, 32'hAA, 4'd0}) begin
            errors++;
            $display("FAIL prio_b_after got rw=%b wreg=%0d wdata=%h cnt=%0d want 1 7 aa 0",
                     regWrite, wreg, wdata, fifo_count);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 32'(k), 1'b1, 5'(20 + k), 32'(256 + k));
            tick();
        end
        drive(1'b1, 5'd1, 32'd9, 1'b1, 5'd24, 32'h104);
        tick();
        checks++;
        if ({fifo_count, b_ready} !== {4'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_stall got cnt=%0d rdy=%b want 4 0", fifo_count, b_ready);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 32'h104);
        tick();
        checks++;
        if ({regWrite, wreg, wdata, fifo_count, b_ready} !== {1'b1, 5'd20, 32'h100, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL full_first_pop got rw=%b wreg=%0d wdata=%h cnt=%0d rdy=%b want 1 20 100 3 1",
                     regWrite, wreg, wdata, fifo_count, b_ready);
        end
        tick();
        b_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if ({regWrite, wreg, wdata} !== {1'b1, 5'(20 + k), 32'(256 + k)}) begin
                errors++;
                $display("FAIL full_order[%0d] got rw=%b wreg=%0d wdata=%h want 1 %0d %h",
                         k, regWrite, wreg, wdata, 20 + k, 256 + k);
            end
            if (k < 4) tick();
        end
        checks++;
        if (fifo_count !== 4'd0) begin
            errors++; $display("FAIL full_drained got cnt=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_waw();
        rreg_a = 5'd9;
        drive(1'b1, 5'd2, 32'd0, 1'b1, 5'd9, 32'h11);
        tick();
        checks++;
        if ({fifo_count, pend_a} !== {4'd1, 1'b1}) begin
            errors++; $display("FAIL waw_queued got cnt=%0d pa=%b want 1 1", fifo_count, pend_a);
        end
        drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata} !== {1'b1, 5'd9, 32'h22}) begin
            errors++;
            $display("FAIL waw_a_write got rw=%b wreg=%0d wdata=%h want 1 9 22", regWrite, wreg, wdata);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, wdata, fifo_count, pend_a} !== {1'b0, 5'd9, 32'h22, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL waw_killed_pop got rw=%b wreg=%0d wdata=%h cnt=%0d pa=%b want 0 9 22 0 0",
                     regWrite, wreg, wdata, fifo_count, pend_a);
        end
    endtask

    task automatic test_hazard();
        rreg_a = 5'd12; rreg_b = 5'd0;
        drive(1'b1, 5'd4, 32'd0, 1'b1, 5'd12, 32'h5);
        tick();
        checks++;
        if ({pend_a, pend_b} !== 2'b10) begin
            errors++; $display("FAIL hazard_queued got pa=%b pb=%b want 1 0", pend_a, pend_b);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++;
        if ({regWrite, wreg, pend_a} !== {1'b1, 5'd12, 1'b1}) begin
            errors++;
            $display("FAIL hazard_writing got rw=%b wreg=%0d pa=%b want 1 12 1", regWrite, wreg, pend_a);
        end
        tick();
        checks++;
        if ({regWrite, pend_a} !== 2'b00) begin
            errors++; $display("FAIL hazard_clear got rw=%b pa=%b want 0 0", regWrite, pend_a);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd1, 32'd0, 1'b1, 5'(13 + k), 32'(k));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();
        checks++;
        if ({fifo_count, regWrite, b_ready} !== {4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got cnt=%0d rw=%b rdy=%b want 0 0 0", fifo_count, regWrite, b_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (regWrite !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_nowrite[%0d] got rw=%b wreg=%0d want rw 0", k, regWrite, wreg);
            end
        end
    endtask

    task automatic test_random();
        logic [44:0] exp;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
            rreg_a = 5'($urandom_range(0, 7));
            rreg_b = 5'($urandom_range(0, 7));
            tick();
            exp = exp_vec();
            checks++;
            if ({regWrite, wreg, wdata, fifo_count, b_ready, pend_a, pend_b} !== exp) begin
                errors++;
                $display("FAIL random[%0d] got rw=%b wreg=%0d wdata=%h cnt=%0d rdy=%b pa=%b pb=%b want %b %0d %h %0d %b %b %b",
                         n, regWrite, wreg, wdata, fifo_count, b_ready, pend_a, pend_b,
                         exp[44], exp[43:39], exp[38:7], exp[6:3], exp[2], exp[1], exp[0]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_a_only();
        test_priority();
        test_full();
        test_waw();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
